// File: rtl/axrm16_error_monitor.sv
// Error-statistics monitor for the 16x16 approximate recursive multiplier.
// Each sample runs a 2-stage pipeline: the exact product, then the ED and the stats update.
module axrm16_error_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      a,
  input  logic [15:0]      b,
  input  logic [31:0]      approx,
  output logic             busy,
  output logic             stats_valid,
  input  logic             stats_ack,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] ed_sum,
  output logic [31:0]      ed_max,
  output logic             sum_sat
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] num_reg, acc_reg;
  logic [31:0]      s1_exact_reg, s1_approx_reg;
  logic             s1_valid_reg;
  logic [CNT_W-1:0] sample_cnt_reg, err_cnt_reg;
  logic [SUM_W-1:0] ed_sum_reg;
  logic [31:0]      ed_max_reg;
  logic             sum_sat_reg;

  logic             start_ok, xfer, last_xfer;
  logic [31:0]      exact;
  logic [32:0]      diff_pos, diff_neg;
  logic [31:0]      ed;
  logic [SUM_W:0]   sum_ext;

  assign start_ok  = start && ((state_reg == IDLE) || (state_reg == REPORT));
  assign in_ready  = (state_reg == RUN) && (acc_reg < num_reg);
  assign xfer      = in_valid && in_ready;
  assign last_xfer = xfer && ((acc_reg + CNT_W'(1)) == num_reg);
  assign exact     = {16'b0, a} * {16'b0, b};

  // ED is |exact - approx|; the sign bit of the 33-bit difference picks which side is larger.
  assign diff_pos = {1'b0, s1_exact_reg} - {1'b0, s1_approx_reg};
  assign diff_neg = {1'b0, s1_approx_reg} - {1'b0, s1_exact_reg};
  assign ed       = diff_pos[32] ? diff_neg[31:0] : diff_pos[31:0];
  assign sum_ext  = {1'b0, ed_sum_reg} + (SUM_W+1)'(ed);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start) state_next = (num_samples == '0) ? REPORT : RUN;
      RUN:    if (last_xfer) state_next = DRAIN;
      DRAIN:  state_next = REPORT;
      REPORT: begin
        if (start)          state_next = (num_samples == '0) ? REPORT : RUN;
        else if (stats_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      num_reg        <= '0;
      acc_reg        <= '0;
      s1_exact_reg   <= '0;
      s1_approx_reg  <= '0;
      s1_valid_reg   <= 1'b0;
      sample_cnt_reg <= '0;
      err_cnt_reg    <= '0;
      ed_sum_reg     <= '0;
      ed_max_reg     <= '0;
      sum_sat_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        num_reg        <= num_samples;
        acc_reg        <= '0;
        s1_valid_reg   <= 1'b0;
        sample_cnt_reg <= '0;
        err_cnt_reg    <= '0;
        ed_sum_reg     <= '0;
        ed_max_reg     <= '0;
        sum_sat_reg    <= 1'b0;
      end else begin
        s1_valid_reg <= xfer;
        if (xfer) begin
          s1_exact_reg  <= exact;
          s1_approx_reg <= approx;
          acc_reg       <= acc_reg + CNT_W'(1);
        end
        if (s1_valid_reg) begin
          sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
          if (ed != 32'd0) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
          if (ed > ed_max_reg) ed_max_reg <= ed;
          // A carry out of the sum means the true total no longer fits: pin at all-ones.
          if (sum_ext[SUM_W]) begin
            ed_sum_reg  <= '1;
            sum_sat_reg <= 1'b1;
          end else begin
            ed_sum_reg <= sum_ext[SUM_W-1:0];
          end
        end
      end
    end
  end

  assign busy        = (state_reg == RUN) || (state_reg == DRAIN);
  assign stats_valid = (state_reg == REPORT);
  assign sample_cnt  = sample_cnt_reg;
  assign err_cnt     = err_cnt_reg;
  assign ed_sum      = ed_sum_reg;
  assign ed_max      = ed_max_reg;
  assign sum_sat     = sum_sat_reg;

endmodule

// File: tb/tb_axrm16_error_monitor.sv
// Directed bench for axrm16_error_monitor: a wide-sum and a narrow (33-bit) sum instance
// share one stimulus stream so saturation can be observed on the narrow one.
module tb_axrm16_error_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_samples = '0;
  logic        in_valid = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [31:0] approx = '0;
  logic        stats_ack = 1'b0;

  logic        in_ready, busy, stats_valid, sum_sat;
  logic [15:0] sample_cnt, err_cnt;
  logic [47:0] ed_sum;
  logic [31:0] ed_max;

  logic        in_ready_s, busy_s, stats_valid_s, sum_sat_s;
  logic [15:0] sample_cnt_s, err_cnt_s;
  logic [32:0] ed_sum_s;
  logic [31:0] ed_max_s;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axrm16_error_monitor #(.CNT_W(16), .SUM_W(48)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .approx(approx),
    .busy(busy), .stats_valid(stats_valid), .stats_ack(stats_ack),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .ed_sum(ed_sum),
    .ed_max(ed_max), .sum_sat(sum_sat)
  );

  axrm16_error_monitor #(.CNT_W(16), .SUM_W(33)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready_s), .a(a), .b(b), .approx(approx),
    .busy(busy_s), .stats_valid(stats_valid_s), .stats_ack(stats_ack),
    .sample_cnt(sample_cnt_s), .err_cnt(err_cnt_s), .ed_sum(ed_sum_s),
    .ed_max(ed_max_s), .sum_sat(sum_sat_s)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1;
    num_samples = n;
    tick();
    start = 1'b0;
  endtask

  // Present one sample and hold it until a transfer edge passes (bounded).
  task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] pv);
    bit done = 0;
    a = av; b = bv; approx = pv; in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 0, 1);
  endtask

  task automatic wait_report(output int cycles);
    cycles = 0;
    while (!stats_valid && cycles < 20) begin
      tick();
      cycles++;
    end
    if (!stats_valid) check("report_timeout", 0, 1);
  endtask

  int cyc;
  int xfers;
  logic [7:0] vpat;

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_stats_valid", stats_valid, 0);
    check("rst_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: reset mid-window
    do_start(16'd5);
    check("t1_busy", busy, 1);
    send(16'd2, 16'd3, 32'd7);
    tick();
    check("t1_partial_cnt", sample_cnt, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_in_ready", in_ready, 0);
    check("t1_rst_busy", busy, 0);
    check("t1_rst_cnt", sample_cnt, 0);
    check("t1_rst_sum", ed_sum, 0);
    check("t1_rst_max", ed_max, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // 2: exact window
    do_start(16'd3);
    send(16'd3, 16'd5, 32'd15);
    send(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    send(16'd0, 16'd7, 32'd0);
    check("t2_ready_low", in_ready, 0);
    wait_report(cyc);
    check("t2_cnt", sample_cnt, 3);
    check("t2_err", err_cnt, 0);
    check("t2_sum", ed_sum, 0);
    check("t2_max", ed_max, 0);
    stats_ack = 1'b1; tick(); stats_ack = 1'b0;
    check("t2_ack_idle", stats_valid, 0);
    check("t2_retained", sample_cnt, 3);

    // 3: mixed error, both signs of difference
    do_start(16'd2);
    send(16'h0100, 16'h0100, 32'h0000FF00);
    send(16'd10, 16'd10, 32'h6E);
    check("t3_drain", busy, 1);
    wait_report(cyc);
    check("t3_latency_ok", (cyc <= 2), 1);
    check("t3_err", err_cnt, 2);
    check("t3_sum", ed_sum, 48'h10A);
    check("t3_max", ed_max, 32'h100);
    stats_ack = 1'b1; tick(); stats_ack = 1'b0;

    // 4: handshake with gaps; each sample has ED 1
    do_start(16'd4);
    vpat = 8'b1110_1101;
    xfers = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = vpat[i];
      a = 16'(i + 1); b = 16'd2; approx = 32'(2 * (i + 1) + 1);
      if (i == 6) check("t4_ready_after_4th", in_ready, 0);
      if (in_valid && in_ready) xfers++;
      tick();
    end
    in_valid = 1'b0;
    check("t4_xfers", xfers, 4);
    wait_report(cyc);
    check("t4_cnt", sample_cnt, 4);
    check("t4_err", err_cnt, 4);
    check("t4_sum", ed_sum, 4);
    check("t4_max", ed_max, 1);
    stats_ack = 1'b1; tick(); stats_ack = 1'b0;

    // 5a: empty window
    do_start(16'd0);
    check("t5_zero_report", stats_valid, 1);
    check("t5_zero_cnt", sample_cnt, 0);
    check("t5_zero_sum", ed_sum, 0);
    check("t5_zero_max", ed_max, 0);
    stats_ack = 1'b1; tick(); stats_ack = 1'b0;

    // 5b: saturation on the 33-bit instance
    do_start(16'd3);
    for (int i = 0; i < 3; i++) send(16'hFFFF, 16'hFFFF, 32'd0);
    wait_report(cyc);
    check("t5_sat_sum", ed_sum_s, 33'h1FFFFFFFF);
    check("t5_sat_flag", sum_sat_s, 1);
    check("t5_sat_max", ed_max_s, 32'hFFFE0001);
    check("t5_wide_sum", ed_sum, 48'h2FFFA0003);
    check("t5_wide_flag", sum_sat, 0);

    // 6: restart from REPORT without ack
    do_start(16'd2);
    check("t6_run", busy, 1);
    check("t6_ready", in_ready, 1);
    check("t6_cleared_cnt", sample_cnt, 0);
    check("t6_cleared_sat", sum_sat_s, 0);
    send(16'd2, 16'd3, 32'd6);
    send(16'd4, 16'd4, 32'd20);
    wait_report(cyc);
    check("t6_cnt", sample_cnt, 2);
    check("t6_err", err_cnt, 1);
    check("t6_sum", ed_sum, 4);
    check("t6_max", ed_max, 4);
    check("t6_sat_sum", ed_sum_s, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
